// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: op encoding, FSM states and
// the priority resolver for the one-hot control word.
package alu_pkg;

    localparam int ALU_OPS = 13;

    localparam int OP_MUL  = 12;
    localparam int OP_ADD  = 11;
    localparam int OP_SUB  = 10;
    localparam int OP_SLT  = 9;
    localparam int OP_SLTU = 8;
    localparam int OP_AND  = 7;
    localparam int OP_NOR  = 6;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 4;
    localparam int OP_SLL  = 3;
    localparam int OP_SRL  = 2;
    localparam int OP_SRA  = 1;
    localparam int OP_LUI  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Keep only the highest set bit: a malformed multi-hot word from decode
    // still selects exactly one operation (mul > add > ... > lui).
    function automatic logic [ALU_OPS-1:0] prio_onehot(input logic [ALU_OPS-1:0] ctrl);
        logic [ALU_OPS-1:0] sel;
        sel = '0;
        for (int i = 0; i < ALU_OPS; i++) begin
            if (ctrl[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, XLEN cycles
// per product. Only the low XLEN bits are kept, so the result is the same
// for signed and unsigned operands.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] acc_q;
    logic [SHW-1:0]  cnt_q;
    logic            busy_q;

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == SHW'(XLEN - 1));
    assign product = acc_q;

    // Load operands on start, then add-and-shift once per cycle until the last bit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + SHW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_hs.sv
// Handshaked XLEN-wide ALU with registered result and signed-overflow flag.
// Optional iterative multiplier enabled by defining ALU_HS_MUL_EN.
//
//   state | meaning
//   IDLE  | accepting ops; single-cycle results registered on accept
//   MUL   | multiplier iterating, input stalled
//   DONE  | product presented, waiting for out_ready
module alu_hs
    import alu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALU_OPS-1:0] alu_control,
    input  logic [XLEN-1:0]    alu_src1,
    input  logic [XLEN-1:0]    alu_src2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    alu_result,
    output logic               alu_ovf
);

    localparam logic [ALU_OPS-1:0] MUL_BIT = ALU_OPS'(1) << OP_MUL;

    alu_state_e         state_q;
    alu_state_e         state_d;
    logic [ALU_OPS-1:0] ctrl_eff;
    logic [ALU_OPS-1:0] op_sel;
    logic               accept;
    logic               accept_single;

    logic               sub_sel;
    logic [XLEN-1:0]    b_eff;
    logic [XLEN:0]      add_full;
    logic [XLEN-1:0]    sum;
    logic               carry;
    logic               add_ovf;
    logic               slt_bit;
    logic               sltu_bit;
    logic [SHW-1:0]     shamt;
    logic [XLEN-1:0]    sll_res;
    logic [XLEN-1:0]    srl_res;
    logic [XLEN-1:0]    sra_res;
    logic signed [31:0] lui_w;
    logic [XLEN-1:0]    alu_res;
    logic               ovf_res;

`ifdef ALU_HS_MUL_EN
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [XLEN-1:0]    mul_product;

    assign ctrl_eff  = alu_control;
    assign in_ready  = resetn && (state_q == IDLE) && !mul_busy && (!out_valid || out_ready);
    assign mul_start = accept && op_sel[OP_MUL];

    alu_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .resetn  (resetn),
        .start   (mul_start),
        .a       (alu_src1),
        .b       (alu_src2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    // Without the multiplier the mul bit is dropped so priority falls through.
    assign ctrl_eff = alu_control & ~MUL_BIT;
    assign in_ready = resetn && (state_q == IDLE) && (!out_valid || out_ready);
`endif

    assign op_sel        = prio_onehot(ctrl_eff);
    assign accept        = in_valid && in_ready;
    assign accept_single = accept && !op_sel[OP_MUL];

    // Shared adder; slt/sltu reuse the subtract path for their compare.
    always_comb begin
        sub_sel  = op_sel[OP_SUB] | op_sel[OP_SLT] | op_sel[OP_SLTU];
        b_eff    = sub_sel ? ~alu_src2 : alu_src2;
        add_full = {1'b0, alu_src1} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub_sel};
        sum      = add_full[XLEN-1:0];
        carry    = add_full[XLEN];
        add_ovf  = (alu_src1[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != alu_src1[XLEN-1]);
        slt_bit  = (alu_src1[XLEN-1] != alu_src2[XLEN-1]) ? alu_src1[XLEN-1] : sum[XLEN-1];
        sltu_bit = ~carry;
    end

    // Barrel shifter on src2, amount from the low bits of src1; lui immediate.
    always_comb begin
        shamt   = alu_src1[SHW-1:0];
        sll_res = alu_src2 << shamt;
        srl_res = alu_src2 >> shamt;
        sra_res = $signed(alu_src2) >>> shamt;
        lui_w   = {alu_src2[15:0], 16'h0000};
    end

    // Result mux over the already priority-resolved op select.
    always_comb begin
        alu_res = '0;
        ovf_res = 1'b0;
        if (op_sel[OP_ADD] || op_sel[OP_SUB]) begin
            alu_res = sum;
            ovf_res = add_ovf;
        end else if (op_sel[OP_SLT]) begin
            alu_res = XLEN'(slt_bit);
        end else if (op_sel[OP_SLTU]) begin
            alu_res = XLEN'(sltu_bit);
        end else if (op_sel[OP_AND]) begin
            alu_res = alu_src1 & alu_src2;
        end else if (op_sel[OP_NOR]) begin
            alu_res = ~(alu_src1 | alu_src2);
        end else if (op_sel[OP_OR]) begin
            alu_res = alu_src1 | alu_src2;
        end else if (op_sel[OP_XOR]) begin
            alu_res = alu_src1 ^ alu_src2;
        end else if (op_sel[OP_SLL]) begin
            alu_res = sll_res;
        end else if (op_sel[OP_SRL]) begin
            alu_res = srl_res;
        end else if (op_sel[OP_SRA]) begin
            alu_res = sra_res;
        end else if (op_sel[OP_LUI]) begin
            alu_res = XLEN'(lui_w);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; collapses to a permanent IDLE without the multiplier.
    always_comb begin
        state_d = state_q;
`ifdef ALU_HS_MUL_EN
        case (state_q)
            IDLE:    if (mul_start) state_d = MUL;
            MUL:     if (mul_done) state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`else
        state_d = IDLE;
`endif
    end

    // Output register: load on accept (or product ready), hold while stalled,
    // drop valid once the consumer takes it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            alu_result <= '0;
            alu_ovf    <= 1'b0;
        end else if (accept_single) begin
            out_valid  <= 1'b1;
            alu_result <= alu_res;
            alu_ovf    <= ovf_res;
        end
`ifdef ALU_HS_MUL_EN
        else if ((state_q == DONE) && !out_valid) begin
            out_valid  <= 1'b1;
            alu_result <= mul_product;
            alu_ovf    <= 1'b0;
        end
`endif
        else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
